// File: rtl/moto_duty_ramp_pkg.sv
// Shared definitions for the motor duty ramp: FSM states, default timing
// constants, duty width and the command clamp helper.
package moto_pkg;

   localparam int unsigned DUTY_W       = 8;
   localparam int unsigned DEF_PERIOD   = 200;
   localparam int unsigned DEF_STEP     = 4;
   localparam int unsigned DEF_HOLD     = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      STOP = 2'd2
   } state_t;

   // Limit a requested duty to the period length.
   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] d,
                                                    input logic [DUTY_W-1:0] lim);
      return (d > lim) ? lim : d;
   endfunction

endpackage

// File: rtl/moto_duty_ramp_if.sv
// Target-duty command handshake between the command source and the ramp.
interface moto_duty_ramp_if;
   import moto_pkg::*;

   logic              cmd_valid;
   logic [DUTY_W-1:0] cmd_duty;
   logic              cmd_ready;

   modport master (output cmd_valid, output cmd_duty, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_duty, output cmd_ready);

endinterface

// File: rtl/moto_duty_ramp_edge_rise_det.sv
// Rising-edge detector: one-cycle strobe per low-to-high transition of level.
module edge_rise_det (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   output logic rise
);

   logic level_d;

   // Remember the previous level so a held-high input strobes only once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) level_d <= 1'b0;
      else        level_d <= level;
   end

   assign rise = level & ~level_d;

endmodule

// File: rtl/moto_duty_ramp.sv
// Duty ramp for one wheel: accepts a target duty, slews the PWM high/low
// time pair toward it at period boundaries, and zeroes it on estop.
module moto_duty_ramp
   import moto_pkg::*;
#(
   parameter int unsigned PERIOD       = DEF_PERIOD,
   parameter int unsigned STEP         = DEF_STEP,
   parameter int unsigned HOLD_PERIODS = DEF_HOLD
) (
   input  logic              clk,
   input  logic              rst_n,
   moto_duty_ramp_if.slave   cmd,
   input  logic              estop,
   input  logic              period_fini,
   output logic [DUTY_W-1:0] spd_high_time,
   output logic [DUTY_W-1:0] spd_low_time,
   output logic              ramp_busy,
   output logic              at_target
);

   localparam logic [DUTY_W-1:0] PERIOD_V  = DUTY_W'(PERIOD);
   localparam logic [DUTY_W-1:0] STEP_V    = DUTY_W'(STEP);
   localparam logic [3:0]        HOLD_LAST = 4'(HOLD_PERIODS - 1);

   state_t            state_q, state_n;
   logic [DUTY_W-1:0] duty_q, duty_n;
   logic [DUTY_W-1:0] target_q, target_n;
   logic [3:0]        per_cnt_q, per_cnt_n;
   logic              ready_q;

   logic              bnd;
   logic              accept;
   logic signed [8:0] diff;
   logic [DUTY_W-1:0] mag;
   logic [DUTY_W-1:0] amt;
   logic [DUTY_W-1:0] stepped;

   edge_rise_det u_bnd (
      .clk   (clk),
      .rst_n (rst_n),
      .level (period_fini),
      .rise  (bnd)
   );

   assign cmd.cmd_ready = ready_q;
   assign accept        = cmd.cmd_valid & ready_q & ~estop;

   // Saturating slew: move at most STEP toward target, never past it.
   always_comb begin
      diff    = $signed({1'b0, target_q}) - $signed({1'b0, duty_q});
      mag     = diff[8] ? DUTY_W'(-diff) : DUTY_W'(diff);
      amt     = (mag > STEP_V) ? STEP_V : mag;
      stepped = diff[8] ? (duty_q - amt) : (duty_q + amt);
   end

   // Next-state logic; estop overrides everything including a pending command.
   always_comb begin
      state_n   = state_q;
      duty_n    = duty_q;
      target_n  = target_q;
      per_cnt_n = per_cnt_q;
      if (accept) target_n = clamp_duty(cmd.cmd_duty, PERIOD_V);
      if (estop) begin
         state_n   = STOP;
         duty_n    = '0;
         target_n  = '0;
         per_cnt_n = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (target_q != duty_q) begin
                  state_n   = WAIT;
                  per_cnt_n = '0;
               end
            end
            WAIT: begin
               // Step is taken against the registered target, so a command
               // arriving with the same boundary applies from the next one.
               if (bnd) begin
                  if (per_cnt_q == HOLD_LAST) begin
                     duty_n    = stepped;
                     per_cnt_n = '0;
                     if (stepped == target_q) state_n = IDLE;
                  end else begin
                     per_cnt_n = per_cnt_q + 4'd1;
                  end
               end
            end
            STOP:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   // State and output registers; outputs derive from next values so the
   // high/low pair is always consistent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         duty_q        <= '0;
         target_q      <= '0;
         per_cnt_q     <= '0;
         ready_q       <= 1'b1;
         spd_high_time <= '0;
         spd_low_time  <= PERIOD_V;
         ramp_busy     <= 1'b0;
         at_target     <= 1'b1;
      end else begin
         state_q       <= state_n;
         duty_q        <= duty_n;
         target_q      <= target_n;
         per_cnt_q     <= per_cnt_n;
         ready_q       <= (state_n != STOP);
         spd_high_time <= duty_n;
         spd_low_time  <= PERIOD_V - duty_n;
         ramp_busy     <= (duty_n != target_n);
         at_target     <= (duty_n == target_n) && (state_n != STOP);
      end
   end

endmodule

// File: tb/tb_moto_duty_ramp.sv
// Directed bench for moto_duty_ramp with PERIOD=200, STEP=4, HOLD_PERIODS=2.
module tb_moto_duty_ramp;

   logic       clk;
   logic       rst_n;
   logic       estop;
   logic       period_fini;
   logic [7:0] spd_high_time;
   logic [7:0] spd_low_time;
   logic       ramp_busy;
   logic       at_target;

   int n_checks = 0;
   int n_fail   = 0;

   moto_duty_ramp_if cmd_if ();

   moto_duty_ramp #(
      .PERIOD       (200),
      .STEP         (4),
      .HOLD_PERIODS (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd           (cmd_if),
      .estop         (estop),
      .period_fini   (period_fini),
      .spd_high_time (spd_high_time),
      .spd_low_time  (spd_low_time),
      .ramp_busy     (ramp_busy),
      .at_target     (at_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_duty  = d;
      tick();
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic pulse();
      period_fini = 1'b1;
      tick();
      period_fini = 1'b0;
      tick();
   endtask

   task automatic check_pair(input string tag, input logic [7:0] hi);
      check({tag, "_high"}, 32'(spd_high_time), 32'(hi));
      check({tag, "_low"},  32'(spd_low_time),  32'(8'd200 - hi));
   endtask

   int exp_d;
   int exp6 [8] = '{24, 20, 20, 16, 16, 12, 12, 8};

   initial begin
      rst_n            = 1'b0;
      estop            = 1'b0;
      period_fini      = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_duty  = '0;
      tick();
      tick();

      // 1: reset values, then idle after release
      check_pair("rst", 8'd0);
      check("rst_ready", 32'(cmd_if.cmd_ready), 1);
      check("rst_at_target", 32'(at_target), 1);
      check("rst_busy", 32'(ramp_busy), 0);
      rst_n = 1'b1;
      tick();
      tick();
      check_pair("idle", 8'd0);
      check("idle_at_target", 32'(at_target), 1);
      check("idle_ready", 32'(cmd_if.cmd_ready), 1);

      // 2: ramp 0 -> 10, steps at bnd #2, #4, #6
      send(8'd10);
      check("cmd10_busy", 32'(ramp_busy), 1);
      check("cmd10_at_target", 32'(at_target), 0);
      tick();
      pulse(); check_pair("r10_b1", 8'd0);
      pulse(); check_pair("r10_b2", 8'd4);
      pulse(); check_pair("r10_b3", 8'd4);
      pulse(); check_pair("r10_b4", 8'd8);
      pulse(); check_pair("r10_b5", 8'd8);
      pulse(); check_pair("r10_b6", 8'd10);
      tick();
      check("r10_at_target", 32'(at_target), 1);
      check("r10_busy", 32'(ramp_busy), 0);

      // 3: command above PERIOD clamps to 200
      send(8'd250);
      tick();
      exp_d = 10;
      for (int k = 1; k <= 96; k++) begin
         pulse();
         if (k % 2 == 0) exp_d = (exp_d + 4 > 200) ? 200 : exp_d + 4;
         check("clamp_high", 32'(spd_high_time), 32'(exp_d));
         check("clamp_sum", 32'(spd_high_time) + 32'(spd_low_time), 200);
      end
      check_pair("clamp_end", 8'd200);
      check("clamp_at_target", 32'(at_target), 1);

      // 4: level held high yields one boundary only
      send(8'd100);
      tick();
      period_fini = 1'b1;
      repeat (20) tick();
      check_pair("held", 8'd200);
      period_fini = 1'b0;
      tick();
      pulse();
      check_pair("held_next", 8'd196);

      // 5: retarget down to 40, then estop mid-ramp
      send(8'd40);
      tick();
      exp_d = 196;
      for (int k = 1; k <= 78; k++) begin
         pulse();
         if (k % 2 == 0) exp_d = (exp_d - 4 < 40) ? 40 : exp_d - 4;
         check("down_high", 32'(spd_high_time), 32'(exp_d));
      end
      check_pair("at40", 8'd40);
      check("at40_at_target", 32'(at_target), 1);
      send(8'd100);
      tick();
      pulse();
      check_pair("pre_estop", 8'd40);
      estop = 1'b1;
      tick();
      check_pair("estop", 8'd0);
      check("estop_ready", 32'(cmd_if.cmd_ready), 0);
      check("estop_at_target", 32'(at_target), 0);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_duty  = 8'd50;
      period_fini      = 1'b1;
      tick();
      cmd_if.cmd_valid = 1'b0;
      period_fini      = 1'b0;
      tick();
      check_pair("estop_hold", 8'd0);
      check("estop_hold_ready", 32'(cmd_if.cmd_ready), 0);
      estop = 1'b0;
      tick();
      check_pair("estop_rel", 8'd0);
      check("estop_rel_ready", 32'(cmd_if.cmd_ready), 1);
      check("estop_rel_at_target", 32'(at_target), 1);
      check("estop_rel_busy", 32'(ramp_busy), 0);
      send(8'd8);
      tick();
      pulse(); check_pair("post_b1", 8'd0);
      pulse(); check_pair("post_b2", 8'd4);
      pulse(); check_pair("post_b3", 8'd4);
      pulse(); check_pair("post_b4", 8'd8);
      check("post_at_target", 32'(at_target), 1);

      // estop with a command in the same cycle drops the command
      estop            = 1'b1;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_duty  = 8'd60;
      tick();
      estop            = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      check_pair("estop_cmd", 8'd0);
      check("estop_cmd_ready", 32'(cmd_if.cmd_ready), 0);
      tick();
      check("estop_cmd_ready2", 32'(cmd_if.cmd_ready), 1);
      check("estop_cmd_at_target", 32'(at_target), 1);
      check("estop_cmd_busy", 32'(ramp_busy), 0);
      tick();
      check_pair("estop_cmd_dropped", 8'd0);

      // 6: reverse retarget in the same cycle as a step boundary
      send(8'd20);
      tick();
      repeat (10) pulse();
      check_pair("at20", 8'd20);
      send(8'd100);
      tick();
      pulse();
      check_pair("rev_pre", 8'd20);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_duty  = 8'd8;
      period_fini      = 1'b1;
      tick();
      cmd_if.cmd_valid = 1'b0;
      period_fini      = 1'b0;
      check_pair("rev_step", 8'd24);
      tick();
      for (int k = 0; k < 8; k++) begin
         pulse();
         check("rev_high", 32'(spd_high_time), 32'(exp6[k]));
      end
      check("rev_at_target", 32'(at_target), 1);
      check("rev_busy", 32'(ramp_busy), 0);

      // asynchronous reset in the middle of a ramp
      send(8'd100);
      tick();
      repeat (4) pulse();
      check_pair("pre_rst", 8'd16);
      #2 rst_n = 1'b0;
      #1;
      check_pair("async_rst", 8'd0);
      check("async_rst_busy", 32'(ramp_busy), 0);
      check("async_rst_at_target", 32'(at_target), 1);
      tick();
      rst_n = 1'b1;
      tick();
      repeat (4) pulse();
      check_pair("after_rst", 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
